// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI pins from the master plus the received-word outputs of spi_slave_rx.
interface spi_slave_rx_if #(
    parameter int DATA_W = 12
);
    logic sclk;
    logic cs;
    logic mosi;
    logic [DATA_W-1:0] dout;
    logic valid;
    logic frame_err;
    logic busy;
    modport slave (input sclk, cs, mosi, output dout, valid, frame_err, busy);
    modport master (output sclk, cs, mosi, input dout, valid, frame_err, busy);
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI receiver; rebuilds LSB-first frames into parallel words.
module spi_slave_rx #(
    parameter int DATA_W = 12,
    parameter int SKIP_LEAD = 1,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst,
    spi_slave_rx_if.slave bus
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int SW = SKIP_LEAD > 0 ? $clog2(SKIP_LEAD + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W);
    localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_LEAD > 0 ? SKIP_LEAD - 1 : 0);
    localparam logic [SW-1:0] SKIP_MAX = SW'(SKIP_LEAD);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, HOLD} state_t;

    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q, fill;
    logic sclk_d, cs_d, armed;
    logic sclk_s, cs_s, mosi_s;
    logic cs_fall, cs_rise, sclk_fall;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [SW-1:0] skip_cnt, skip_n;
    logic [DATA_W-1:0] shreg, shreg_n, dout, dout_n;
    logic valid, valid_n, frame_err, err_n;

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign cs_s = cs_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    // A frame may only start once a real (post-reset) high level of cs has been seen.
    assign cs_fall = armed & cs_d & ~cs_s;
    assign cs_rise = ~cs_d & cs_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q <= '1;
            mosi_q <= '0;
            fill <= '0;
            sclk_d <= 1'b0;
            cs_d <= 1'b1;
            armed <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.sclk};
            cs_q <= {cs_q[SYNC_STAGES-2:0], bus.cs};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
            fill <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_d <= sclk_s;
            cs_d <= cs_s;
            armed <= armed | (fill[SYNC_STAGES-1] & cs_s);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bit_cnt <= '0;
            skip_cnt <= '0;
            shreg <= '0;
            dout <= '0;
            valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_n;
            bit_cnt <= bit_n;
            skip_cnt <= skip_n;
            shreg <= shreg_n;
            dout <= dout_n;
            valid <= valid_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        bit_n = bit_cnt;
        skip_n = skip_cnt;
        shreg_n = shreg;
        dout_n = dout;
        valid_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n = SKIP_LEAD == 0 ? SHIFT : LEAD;
                    bit_n = '0;
                    skip_n = '0;
                end
            end
            LEAD: begin
                if (cs_rise) begin
                    err_n = 1'b1;
                    state_n = IDLE;
                end else if (sclk_fall) begin
                    skip_n = skip_cnt == SKIP_MAX ? skip_cnt : skip_cnt + 1'b1;
                    state_n = skip_cnt == SKIP_LAST ? SHIFT : LEAD;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    err_n = 1'b1;
                    state_n = IDLE;
                end else if (sclk_fall) begin
                    shreg_n = {mosi_s, shreg[DATA_W-1:1]};
                    bit_n = bit_cnt == BIT_MAX ? bit_cnt : bit_cnt + 1'b1;
                    state_n = bit_cnt == BIT_LAST ? HOLD : SHIFT;
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    dout_n = shreg;
                    valid_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.dout = dout;
    assign bus.valid = valid;
    assign bus.frame_err = frame_err;
    assign bus.busy = state != IDLE;
endmodule
